// File: rtl/sig_pkg.sv
// Shared definitions for the signal capture/replay block: FSM states and default widths.
package sig_pkg;

    localparam int DEFAULT_ADDRESS_WIDTH = 9;
    localparam int DEFAULT_DATA_WIDTH    = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FETCH   = 2'd2,
        PRESENT = 2'd3
    } state_t;

endpackage

// File: rtl/ram2p.sv
// Simple dual-port RAM: one write port, one registered read port (one-cycle latency).
module ram2p
    import sig_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0]    din,
    output logic [DATA_WIDTH-1:0]    dout
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDRESS_WIDTH)-1];

    // Same-address collisions return the data being written, so a sample
    // written on the last capture cycle can be read back straight away.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= din;
        end
        if (wr_en && (wr_addr == rd_addr)) begin
            dout <= din;
        end else begin
            dout <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sig_replay.sv
// Captures a burst of strobed samples into RAM, then replays them over a
// valid/ready stream, optionally looping.
module sig_replay
    import sig_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] length,
    input  logic                     loop,
    input  logic [DATA_WIDTH-1:0]    mic_signal,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     busy,
    output logic                     done
);

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] len_q;
    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic [ADDRESS_WIDTH-1:0] rd_ptr;
    logic [ADDRESS_WIDTH-1:0] rd_addr;
    logic [ADDRESS_WIDTH-1:0] last_addr;
    logic [DATA_WIDTH-1:0]    ram_dout;
    logic                     wr_en;
    logic                     accept;
    logic                     handshake;
    logic                     at_last;

    assign last_addr = len_q - 1'b1;
    assign at_last   = (rd_ptr == last_addr);
    assign accept    = (state == IDLE) && start && (length != '0);
    assign handshake = (state == PRESENT) && out_valid && out_ready;
    assign wr_en     = (state == CAPTURE) && en;

    // The read address runs one step ahead of rd_ptr so that the RAM output
    // is already valid during FETCH and can be registered on entry to PRESENT.
    always_comb begin
        rd_addr = rd_ptr;
        if (accept) begin
            rd_addr = '0;
        end else if (handshake) begin
            if (!at_last) begin
                rd_addr = rd_ptr + 1'b1;
            end else if (loop) begin
                rd_addr = '0;
            end
        end
    end

    ram2p #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(wr_ptr),
        .rd_addr(rd_addr),
        .din    (mic_signal),
        .dout   (ram_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        len_q  <= length;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        busy   <= 1'b1;
                        state  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (wr_en) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (wr_ptr == last_addr) begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    out_data  <= ram_dout;
                    out_valid <= 1'b1;
                    state     <= PRESENT;
                end
                PRESENT: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        rd_ptr    <= rd_addr;
                        if (at_last && !loop) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sig_replay.sv
// Self-checking bench for sig_replay: random samples and strobes, with the
// expected replay stream kept as a plain queue of captured samples.
module tb_sig_replay;

    localparam int AW = 9;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          start;
    logic [AW-1:0] length;
    logic          loop;
    logic [DW-1:0] mic_signal;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;

    int tests    = 0;
    int failures = 0;

    logic [DW-1:0] model_q [$];
    logic [DW-1:0] given_q [$];

    sig_replay #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .start     (start),
        .length    (length),
        .loop      (loop),
        .mic_signal(mic_signal),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Everything is driven and sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_output("reset_valid", out_valid, 0);
        check_output("reset_data", out_data, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_done", done, 0);
    endtask

    // Issues start, feeds samples with the chosen strobe pattern, and leaves
    // the bench sitting on the first PRESENT cycle.
    task automatic apply_stimulus(input int len, input bit rand_en, input bit use_given);
        int            cyc;
        logic [DW-1:0] sample;
        model_q.delete();
        start  = 1'b1;
        length = AW'(len);
        tick();
        start  = 1'b0;
        length = AW'($urandom);
        check_output("start_busy", busy, 1);
        cyc = 0;
        while (model_q.size() < len) begin
            en = (rand_en && cyc < 3 * len) ? 1'($urandom_range(1, 0)) : 1'b1;
            sample = (use_given && en) ? given_q[model_q.size()] : DW'($urandom);
            mic_signal = sample;
            tick();
            if (en) model_q.push_back(sample);
            cyc++;
            if (model_q.size() < len) check_output("capture_no_valid", out_valid, 0);
        end
        en = 1'b0;
        mic_signal = DW'($urandom);
        check_output("fetch_gap_valid", out_valid, 0);
        check_output("fetch_busy", busy, 1);
        tick();
    endtask

    // Consumes the replay stream: loops full passes with loop held high, then
    // one final pass with loop low from its first sample.
    task automatic play(input int loops, input int first_stall, input int max_stall, input bit poke_start);
        int            stall;
        logic [DW-1:0] held;
        bit            last;
        for (int p = 0; p <= loops; p++) begin
            for (int i = 0; i < model_q.size(); i++) begin
                loop = (p < loops);
                last = (i == model_q.size() - 1);
                check_output("present_valid", out_valid, 1);
                check_output("present_data", out_data, model_q[i]);
                held  = model_q[i];
                stall = (p == 0 && i == 0) ? first_stall : $urandom_range(max_stall, 0);
                for (int s = 0; s < stall; s++) begin
                    out_ready = 1'b0;
                    if (poke_start && s == 0) begin
                        start  = 1'b1;
                        length = AW'($urandom_range(9, 1));
                    end
                    tick();
                    start = 1'b0;
                    check_output("stall_valid", out_valid, 1);
                    check_output("stall_data", out_data, held);
                end
                out_ready = 1'b1;
                tick();
                out_ready = 1'b0;
                check_output("handshake_valid_drop", out_valid, 0);
                if (last && p == loops) begin
                    check_output("end_done", done, 1);
                    check_output("end_busy", busy, 0);
                    tick();
                    check_output("done_single", done, 0);
                    check_output("idle_valid", out_valid, 0);
                    check_output("idle_data_retained", out_data, held);
                end else begin
                    check_output("mid_done", done, 0);
                    check_output("mid_busy", busy, 1);
                    tick();
                end
            end
        end
        loop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; start = 1'b0; length = '0; loop = 1'b0;
        mic_signal = '0; out_ready = 1'b0;
        do_reset();

        // Four continuous samples, plain single pass
        given_q = '{8'd10, 8'd20, 8'd30, 8'd40};
        apply_stimulus(4, 1'b0, 1'b1);
        play(0, 0, 0, 1'b0);

        // Gappy strobe: only strobed samples end up in the stream
        apply_stimulus(3, 1'b1, 1'b0);
        play(0, 0, 0, 1'b0);

        // Backpressure on the first sample, start poked while presenting
        apply_stimulus(5, 1'b1, 1'b0);
        play(0, 5, 2, 1'b1);

        // Looping pair, dropped during the first sample of the third pass
        given_q = '{8'd5, 8'd6};
        apply_stimulus(2, 1'b0, 1'b1);
        play(2, 0, 1, 1'b0);

        // Zero-length start is ignored, strobes in IDLE do nothing
        start = 1'b1; length = '0; en = 1'b1;
        tick();
        start = 1'b0; en = 1'b0;
        check_output("zero_len_busy", busy, 0);
        check_output("zero_len_done", done, 0);
        tick();
        check_output("zero_len_busy_later", busy, 0);

        // Single-sample capture exercises the write/read collision path
        apply_stimulus(1, 1'b0, 1'b0);
        play(1, 1, 1, 1'b0);

        // Reset mid-playback, competing with start and a handshake
        apply_stimulus(6, 1'b1, 1'b0);
        check_output("rst_pre_data0", out_data, model_q[0]);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        check_output("rst_pre_data1", out_data, model_q[1]);
        rst = 1'b1; start = 1'b1; length = AW'(3); out_ready = 1'b1;
        tick();
        check_output("rst_mid_valid", out_valid, 0);
        check_output("rst_mid_busy", busy, 0);
        check_output("rst_mid_done", done, 0);
        check_output("rst_mid_data", out_data, 0);
        rst = 1'b0; start = 1'b0; out_ready = 1'b0;
        tick();
        check_output("rst_after_busy", busy, 0);
        check_output("rst_after_done", done, 0);
        apply_stimulus(7, 1'b1, 1'b0);
        play(0, 2, 2, 1'b0);

        // Random rounds
        for (int r = 0; r < 6; r++) begin
            apply_stimulus($urandom_range(16, 1), 1'b1, 1'b0);
            play($urandom_range(2, 0), $urandom_range(3, 1), 3, 1'($urandom_range(1, 0)));
        end

        // Largest capture the pointer width allows
        apply_stimulus((1 << AW) - 1, 1'b0, 1'b0);
        play(0, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/sig_replay.md
SIG_REPLAY -- requirements
Module: sig_replay

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 9, RAM address width; buffer depth is 2^ADDRESS_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, sample width.
REQ-003 SHALL have port clk  in  1  clock; all logic on the rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port en  in  1  sample strobe; qualifies mic_signal during capture.
REQ-006 SHALL have port start  in  1  single-cycle request to begin capture; honoured only in IDLE.
REQ-007 SHALL have port length  in  ADDRESS_WIDTH  samples to capture; sampled on the accepted start cycle.
REQ-008 SHALL have port loop  in  1  when 1, playback restarts at address 0 after the last sample.
REQ-009 SHALL have port mic_signal  in  DATA_WIDTH  input sample.
REQ-010 SHALL have port out_ready  in  1  downstream accepts out_data this cycle.
REQ-011 SHALL have port out_valid  out  1  out_data holds a valid replay sample.
REQ-012 SHALL have port out_data  out  DATA_WIDTH  replay sample.
REQ-013 SHALL have port busy  out  1  high in every state except IDLE.
REQ-014 SHALL have port done  out  1  one-cycle pulse when non-looping playback completes.

Function
REQ-015 SHALL implement FSM states IDLE, CAPTURE, FETCH, PRESENT.
REQ-016 IDLE -> CAPTURE on start=1 with length!=0; start with length=0 SHALL be ignored (remain IDLE, no done).
REQ-017 On accepted start SHALL latch length into len_q and clear write and read pointers to 0.
REQ-018 In CAPTURE, each en=1 cycle SHALL write mic_signal to RAM at wr_ptr and increment wr_ptr; en=0 cycles write nothing.
REQ-019 CAPTURE -> FETCH on the cycle the write to address len_q-1 occurs.
REQ-020 In FETCH SHALL present rd_ptr to the RAM read port; FETCH -> PRESENT unconditionally next cycle.
REQ-021 RAM read latency SHALL be one cycle; entering PRESENT, out_data SHALL be registered from RAM dout and out_valid=1.
REQ-022 In PRESENT, out_valid and out_data SHALL hold stable until out_valid & out_ready.
REQ-023 On handshake with rd_ptr!=len_q-1: rd_ptr+1, -> FETCH, out_valid=0 next cycle.
REQ-024 On handshake with rd_ptr==len_q-1 and loop=1: rd_ptr=0, -> FETCH, no done.
REQ-025 On handshake with rd_ptr==len_q-1 and loop=0: -> IDLE, done=1 for the next single cycle, out_valid=0.
REQ-026 loop SHALL be evaluated only at the last-sample handshake; changes mid-pass take effect then.
REQ-027 Maximum playback throughput SHALL be one sample per two cycles with out_ready held high.
REQ-028 start SHALL be ignored while busy=1; mic_signal and en SHALL be ignored outside CAPTURE.
REQ-029 Pointers SHALL be ADDRESS_WIDTH wide; len_q never exceeds 2^ADDRESS_WIDTH-1, so no wrap occurs within a capture.
REQ-030 out_data SHALL retain its last value outside PRESENT; only out_valid qualifies it.

Reset
REQ-031 rst=1 SHALL force state IDLE, out_valid=0, out_data=0, busy=0, done=0, pointers=0, len_q=0.
REQ-032 rst during CAPTURE or playback SHALL abort immediately with no done pulse; RAM contents are undefined afterwards.
REQ-033 rst SHALL take priority over start and over any handshake in the same cycle.

Structure
REQ-034 State enum and default widths SHALL live in shared package sig_pkg.
REQ-035 Storage SHALL be one instance of the existing dual-port RAM sub-module ram2p (clk, wr_en, wr_addr, rd_addr, din, dout).

Verification
REQ-036 Capture length=4, en=1 continuous, samples 10,20,30,40, out_ready=1, loop=0 -> out_data 10,20,30,40 on alternate cycles, done one cycle after the fourth handshake, busy=0.
REQ-037 Capture length=3 with en toggling 1,0,1,0,1 -> only strobed samples stored; FETCH entered after the third write.
REQ-038 Backpressure: out_ready=0 for 5 cycles in PRESENT -> out_valid=1, out_data constant throughout; sample advances only after out_ready=1.
REQ-039 loop=1, length=2, samples 5,6 -> out_data 5,6,5,6,...; drop loop during sample 5 -> stream ends after 6 with done.
REQ-040 start with length=0 -> busy stays 0; start during PRESENT -> ignored, playback sequence unchanged.
REQ-041 rst asserted mid-playback -> next cycle out_valid=0, busy=0, done=0; new start captures fresh data correctly.
